// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce motion engine.
// Holds the sweep FSM state encoding, the direction encoding and default geometry.
// No logic of its own; imported by bounce_axis and bounce_motion_engine.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Per-axis direction: 0 moves towards larger coordinates, 1 towards zero.
  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  localparam int DEF_N_OBJ = 2;
  localparam int DEF_X_W   = 10;
  localparam int DEF_Y_W   = 10;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_OBJ_W = 32;
  localparam int DEF_OBJ_H = 16;
  localparam int DEF_SPD_W = 2;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One-axis step with edge reflection: moves pos by mag and clamps/reflects at 0 or limit.
// Latency: purely combinational, no state.
// Backpressure: none; result is valid whenever the inputs are.
// Ports: pos_i/dir_i current position and direction, mag_i step size, limit_i highest legal
//        position; new_pos_o/new_dir_o next position and direction, hit_o edge reached.
module bounce_axis
  import bounce_pkg::*;
#(
  parameter int W  = 10,
  parameter int MW = 3
) (
  input  logic [W-1:0]  pos_i,
  input  logic          dir_i,
  input  logic [MW-1:0] mag_i,
  input  logic [W-1:0]  limit_i,
  output logic [W-1:0]  new_pos_o,
  output logic          new_dir_o,
  output logic          hit_o
);

  // One extra bit so pos+mag can never wrap before the limit compare.
  logic [W:0] pos_ext;
  logic [W:0] mag_ext;
  logic [W:0] sum;

  always_comb begin
    pos_ext   = {1'b0, pos_i};
    mag_ext   = (W+1)'(mag_i);
    sum       = pos_ext + mag_ext;
    new_pos_o = pos_i;
    new_dir_o = dir_i;
    hit_o     = 1'b0;
    if (dir_i == DIR_INC) begin
      if (sum >= {1'b0, limit_i}) begin
        new_pos_o = limit_i;
        new_dir_o = DIR_DEC;
        hit_o     = 1'b1;
      end else begin
        new_pos_o = sum[W-1:0];
      end
    end else begin
      if (pos_ext <= mag_ext) begin
        new_pos_o = '0;
        new_dir_o = DIR_INC;
        hit_o     = 1'b1;
      end else begin
        new_pos_o = pos_i - W'(mag_i);
      end
    end
  end

endmodule

// File: rtl/bounce_motion_engine.sv
// Frame-synchronous sprite mover: each accepted frame_tick sweeps all sprites, one per clock.
// Latency: sprite k written at edge k+1 after the tick; done in the sweep's last cycle (N_OBJ+1 total).
// Backpressure: none; a tick arriving mid-sweep is dropped and latches the sticky overrun flag.
// Ports: clk, rst_n (async, active-low), ena/pause gate tick acceptance, speed_sel = step-1;
//        obj_x/obj_y packed positions, bounce_evt/corner_evt per-update pulses, busy/done/overrun.
module bounce_motion_engine
  import bounce_pkg::*;
#(
  parameter int N_OBJ = DEF_N_OBJ,
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int OBJ_W = DEF_OBJ_W,
  parameter int OBJ_H = DEF_OBJ_H,
  parameter int SPD_W = DEF_SPD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 frame_tick,
  input  logic                 pause,
  input  logic [SPD_W-1:0]     speed_sel,
  output logic [N_OBJ*X_W-1:0] obj_x,
  output logic [N_OBJ*Y_W-1:0] obj_y,
  output logic [N_OBJ-1:0]     bounce_evt,
  output logic                 corner_evt,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int MW    = SPD_W + 1;
  localparam logic [X_W-1:0] LIM_X = X_W'(H_RES - OBJ_W);
  localparam logic [Y_W-1:0] LIM_Y = Y_W'(V_RES - OBJ_H);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  // Geometry sanity: reset layout must fit and a single step must be shorter than the travel.
  if (N_OBJ < 1 || N_OBJ > 8) begin : g_bad_n_obj
    $error("bounce_motion_engine: N_OBJ must be 1..8");
  end
  if (N_OBJ * OBJ_W > H_RES - OBJ_W) begin : g_bad_fit_x
    $error("bounce_motion_engine: reset layout exceeds horizontal travel");
  end
  if (N_OBJ * OBJ_H > V_RES - OBJ_H) begin : g_bad_fit_y
    $error("bounce_motion_engine: reset layout exceeds vertical travel");
  end
  if ((1 << SPD_W) >= min_int(H_RES - OBJ_W, V_RES - OBJ_H)) begin : g_bad_speed
    $error("bounce_motion_engine: maximum step not below travel range");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [MW-1:0]    mag_q;
  logic [X_W-1:0]   x_q [N_OBJ];
  logic [Y_W-1:0]   y_q [N_OBJ];
  logic [N_OBJ-1:0] dirx_q;
  logic [N_OBJ-1:0] diry_q;
  logic [N_OBJ-1:0] bounce_q;
  logic             corner_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;

  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  logic           dirx_d;
  logic           diry_d;
  logic           hit_x;
  logic           hit_y;

  // Both axis units see the sprite currently selected by the sweep index.
  bounce_axis #(.W(X_W), .MW(MW)) u_axis_x (
    .pos_i    (x_q[idx_q]),
    .dir_i    (dirx_q[idx_q]),
    .mag_i    (mag_q),
    .limit_i  (LIM_X),
    .new_pos_o(x_d),
    .new_dir_o(dirx_d),
    .hit_o    (hit_x)
  );

  bounce_axis #(.W(Y_W), .MW(MW)) u_axis_y (
    .pos_i    (y_q[idx_q]),
    .dir_i    (diry_q[idx_q]),
    .mag_i    (mag_q),
    .limit_i  (LIM_Y),
    .new_pos_o(y_d),
    .new_dir_o(diry_d),
    .hit_o    (hit_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mag_q     <= '0;
      bounce_q  <= '0;
      corner_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i]    <= X_W'(i * OBJ_W);
        y_q[i]    <= Y_W'(i * OBJ_H);
        dirx_q[i] <= i[0];
        diry_q[i] <= i[1];
      end
    end else begin
      // Event and done outputs are single-cycle pulses unless re-armed below.
      bounce_q <= '0;
      corner_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_tick && ena && !pause) begin
            state_q <= UPDATE;
            idx_q   <= '0;
            mag_q   <= MW'(speed_sel) + MW'(1);
            busy_q  <= 1'b1;
          end
        end
        UPDATE: begin
          x_q[idx_q]      <= x_d;
          y_q[idx_q]      <= y_d;
          dirx_q[idx_q]   <= dirx_d;
          diry_q[idx_q]   <= diry_d;
          bounce_q[idx_q] <= hit_x | hit_y;
          corner_q        <= hit_x & hit_y;
          if (frame_tick) overrun_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (frame_tick) overrun_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      obj_x[i*X_W +: X_W] = x_q[i];
      obj_y[i*Y_W +: Y_W] = y_q[i];
    end
  end

  assign bounce_evt = bounce_q;
  assign corner_evt = corner_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_bounce_motion_engine.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes hand-computed expectations, the monitor pops and compares
// on every done pulse (sweep results) or on a snapshot request (idle/reset state).
// Playfield is 640x64 so sprite 1 reaches a true corner (x=0, y=48) within a few sweeps.
module tb_bounce_motion_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  speed_sel = 2'd0;
  logic [19:0] obj_x;
  logic [19:0] obj_y;
  logic [1:0]  bounce_evt;
  logic        corner_evt;
  logic        busy;
  logic        done;
  logic        overrun;

  bounce_motion_engine #(
    .N_OBJ(2), .X_W(10), .Y_W(10), .H_RES(640), .V_RES(64),
    .OBJ_W(32), .OBJ_H(16), .SPD_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .pause(pause),
    .speed_sel(speed_sel), .obj_x(obj_x), .obj_y(obj_y), .bounce_evt(bounce_evt),
    .corner_evt(corner_evt), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: sweep result checked at done; kind 1: snapshot checked on request.
  typedef struct {
    int kind; int seq; int tcyc;
    int x0; int x1; int y0; int y1;
    int b0; int b1; int c; int ov; int bsy; int nsw;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   nsweep = 0;
  int   bc0 = 0, bc1 = 0, cc = 0;
  int   issued = 0;
  int   last_t = 0;
  logic snap_req = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      bc0 = 0; bc1 = 0; cc = 0;
    end else begin
      bc0 += int'(bounce_evt[0]);
      bc1 += int'(bounce_evt[1]);
      cc  += int'(corner_evt);
      if (done) begin
        nsweep++;
        if (q.size() > 0 && q[0].kind == 0 && q[0].seq == nsweep) begin
          me = q.pop_front();
          chk($sformatf("sweep%0d_x0", me.seq), int'(obj_x[9:0]), me.x0);
          chk($sformatf("sweep%0d_x1", me.seq), int'(obj_x[19:10]), me.x1);
          chk($sformatf("sweep%0d_y0", me.seq), int'(obj_y[9:0]), me.y0);
          chk($sformatf("sweep%0d_y1", me.seq), int'(obj_y[19:10]), me.y1);
          chk($sformatf("sweep%0d_bounce0_pulses", me.seq), bc0, me.b0);
          chk($sformatf("sweep%0d_bounce1_pulses", me.seq), bc1, me.b1);
          chk($sformatf("sweep%0d_corner_pulses", me.seq), cc, me.c);
          chk($sformatf("sweep%0d_overrun", me.seq), int'(overrun), me.ov);
          chk($sformatf("sweep%0d_busy_with_done", me.seq), int'(busy), 1);
          chk($sformatf("sweep%0d_done_latency", me.seq), cyc - me.tcyc, 3);
        end
        bc0 = 0; bc1 = 0; cc = 0;
      end
    end
    if (snap_req) begin
      if (q.size() > 0 && q[0].kind == 1) begin
        me = q.pop_front();
        chk($sformatf("snap%0d_x0", me.seq), int'(obj_x[9:0]), me.x0);
        chk($sformatf("snap%0d_x1", me.seq), int'(obj_x[19:10]), me.x1);
        chk($sformatf("snap%0d_y0", me.seq), int'(obj_y[9:0]), me.y0);
        chk($sformatf("snap%0d_y1", me.seq), int'(obj_y[19:10]), me.y1);
        chk($sformatf("snap%0d_busy", me.seq), int'(busy), me.bsy);
        chk($sformatf("snap%0d_overrun", me.seq), int'(overrun), me.ov);
        chk($sformatf("snap%0d_done", me.seq), int'(done), 0);
        chk($sformatf("snap%0d_events", me.seq), int'({corner_evt, bounce_evt}), 0);
        chk($sformatf("snap%0d_sweeps", me.seq), nsweep, me.nsw);
        chk($sformatf("snap%0d_pending", me.seq), q.size(), 0);
      end else begin
        total++;
        bad++;
        $display("FAIL snap_order: front entry is not a snapshot, %0d entries pending", q.size());
      end
    end
  end

  int nsnap = 0;

  task automatic snap(input int x0, input int x1, input int y0, input int y1,
                      input int bsy, input int ov, input int nsw);
    exp_t e;
    nsnap++;
    e = '{kind: 1, seq: nsnap, tcyc: 0, x0: x0, x1: x1, y0: y0, y1: y1,
          b0: 0, b1: 0, c: 0, ov: ov, bsy: bsy, nsw: nsw};
    q.push_back(e);
    @(posedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    #1 snap_req = 1'b0;
  endtask

  task automatic do_tick(input logic [1:0] sel);
    @(negedge clk);
    speed_sel  = sel;
    frame_tick = 1'b1;
    last_t     = cyc;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic sweep(input logic [1:0] sel, input bit chk_it,
                       input int x0, input int x1, input int y0, input int y1,
                       input int b0, input int b1, input int c, input int ov);
    exp_t e;
    do_tick(sel);
    issued++;
    if (chk_it) begin
      e = '{kind: 0, seq: issued, tcyc: last_t, x0: x0, x1: x1, y0: y0, y1: y1,
            b0: b0, b1: b1, c: c, ov: ov, bsy: 1, nsw: 0};
      q.push_back(e);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    ena = 1'b1;
    repeat (2) @(negedge clk);
    snap(0, 32, 0, 16, 0, 0, 0);            // held in reset
    rst_n = 1'b1;
    snap(0, 32, 0, 16, 0, 0, 0);            // after release

    // First sweep, step 1: sprite0 (1,1), sprite1 moves left/down to (31,17).
    sweep(2'd0, 1'b1, 1, 31, 1, 17, 0, 0, 0, 0);

    // Ticks gated by pause and by ena are discarded without side effects.
    pause = 1'b1;
    do_tick(2'd0);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    snap(1, 31, 1, 17, 0, 0, 1);
    ena = 1'b0;
    do_tick(2'd0);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    snap(1, 31, 1, 17, 0, 0, 1);

    // Second tick lands during the sweep: overrun set, one advance only.
    do_tick(2'd0);
    issued++;
    e = '{kind: 0, seq: issued, tcyc: last_t, x0: 2, x1: 30, y0: 2, y1: 18,
          b0: 0, b1: 0, c: 0, ov: 1, bsy: 1, nsw: 0};
    q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    snap(2, 30, 2, 18, 0, 1, 2);

    // Step 4: sprite1 walks diagonally into (0,48) and hits both walls at once.
    for (int k = 1; k <= 6; k++) sweep(2'd3, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
    sweep(2'd3, 1'b1, 30, 2, 30, 46, 0, 0, 0, 1);
    sweep(2'd3, 1'b1, 34, 0, 34, 48, 0, 1, 1, 1);
    sweep(2'd3, 1'b1, 38, 4, 38, 44, 0, 0, 0, 1);   // both sprite1 directions flipped

    // Sprite0 travels right to x=606, then hits the right wall and comes back.
    for (int t = 2; t <= 142; t++) sweep(2'd3, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
    sweep(2'd3, 1'b1, 606, 572, 28, 44, 0, 0, 0, 1);
    sweep(2'd3, 1'b1, 608, 576, 32, 48, 1, 1, 0, 1);
    sweep(2'd3, 1'b1, 604, 580, 36, 44, 0, 0, 0, 1);
    snap(604, 580, 36, 44, 0, 1, 155);

    // Reset one cycle after the first write of a sweep: everything back to reset values.
    do_tick(2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    snap(0, 32, 0, 16, 0, 0, 155);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    snap(0, 32, 0, 16, 0, 0, 155);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bounce_motion_engine.md
# bounce_motion_engine

Frame-synchronous motion engine for the capsule demo. It tracks N_OBJ rectangular sprites inside an H_RES×V_RES playfield. On each frame tick it advances every sprite by its velocity and reflects any sprite that reaches a playfield edge. It sits between the video timing generator, which supplies frame_tick, and the pixel renderer, which reads the obj_x/obj_y buses. Sprites are updated sequentially, one per clock, so the renderer sees stable positions outside the update window.

## Interface
- N_OBJ, 2: number of sprites (1..8)
- X_W, 10: x-coordinate width
- Y_W, 10: y-coordinate width
- H_RES, 640: playfield width in pixels
- V_RES, 480: playfield height in pixels
- OBJ_W, 32: sprite width
- OBJ_H, 16: sprite height
- SPD_W, 2: speed-select width

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- ena  in  1  design enable; when low, frame_tick is ignored
- frame_tick  in  1  one-cycle pulse at vblank start
- pause  in  1  when high, frame_tick starts no sweep
- speed_sel  in  SPD_W  step magnitude minus 1
- obj_x  out  N_OBJ*X_W  sprite left edges; sprite i at [i*X_W +: X_W]
- obj_y  out  N_OBJ*Y_W  sprite top edges
- bounce_evt  out  N_OBJ  one-cycle pulse when sprite i reflects on any axis
- corner_evt  out  1  one-cycle pulse when a sprite reflects on both axes in the same update
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- overrun  out  1  sticky flag: frame_tick arrived while busy

## Operation
- Reset state:
  - sprite i: x = i*OBJ_W, y = i*OBJ_H
  - dir_x(i) = i[0], dir_y(i) = i[1] (0 = increasing, 1 = decreasing)
  - FSM in IDLE; all pulse outputs, busy and overrun are 0
- FSM states:
  - IDLE: frame_tick & ena & ~pause → UPDATE with idx=0; latch mag = speed_sel+1
  - UPDATE: write sprite idx; idx == N_OBJ-1 → DONE, else idx+1
  - DONE: done=1 for one cycle → IDLE
- Per-axis step, with limit = H_RES-OBJ_W (x) or V_RES-OBJ_H (y):
  - Increasing direction, pos+mag ≥ limit: pos=limit, dir flips, hit.
  - Decreasing direction, pos ≤ mag: pos=0, dir flips, hit.
  - Otherwise pos ± mag, no hit.
  - Landing exactly on a limit counts as a hit.
  - Compare at X_W+1 / Y_W+1 bits; no wrap-around ever occurs.
- Events:
  - bounce_evt[idx] = hit_x | hit_y, asserted in the cycle after that sprite's write edge.
  - corner_evt = hit_x & hit_y for the same sprite.
- overrun: set by frame_tick while busy (UPDATE or DONE). The tick is otherwise dropped. Cleared only by reset.
- ena low or pause high in IDLE: positions hold, tick is discarded, overrun is unaffected. ena and pause are ignored once a sweep has started.
- Reset mid-sweep returns all state to reset values immediately; the partial sweep is lost.
- Elaboration assertions: N_OBJ*OBJ_W ≤ H_RES-OBJ_W, N_OBJ*OBJ_H ≤ V_RES-OBJ_H, and 2^SPD_W < min(H_RES-OBJ_W, V_RES-OBJ_H).

## Timing
- frame_tick sampled at edge E0.
- busy=1 from E0 until E(N_OBJ+1).
- Sprite k updated at edge E(k+1); its bounce_evt/corner_evt are high in the cycle following E(k+1).
- done is high in the cycle following E(N_OBJ+1) minus one, i.e. the cycle while the FSM is in DONE; busy is also high in that cycle.
- Total sweep: N_OBJ+1 cycles. The next tick is accepted from E(N_OBJ+2).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package bounce_pkg holds:
  - state enum {IDLE, UPDATE, DONE}
  - direction constants DIR_INC=0, DIR_DEC=1
  - default resolution and sprite-size constants
- Sub-module bounce_axis is purely combinational: pos, dir, mag, limit → new_pos, new_dir, hit. It is parametrised by width and instantiated once per axis.
- Top level holds the FSM, index counter, position/direction register arrays and the event registers.

## Test plan
- Reset release: defaults, N_OBJ=2 → obj_x={32,0}, obj_y={16,0}; busy=0, overrun=0.
- One tick, speed_sel=0: sprite0 → (1,1), sprite1 → (31,17) with dir_x=1. done asserted exactly 3 cycles after tick.
- Right-wall hit: x=606, dir_x=0, speed_sel=3 (mag 4) → x=608, dir_x flips, bounce_evt[0] pulses once. Next tick → x=604.
- Corner hit: sprite at (1,1), decreasing on both axes, mag 2 → (0,0), both directions flip, corner_evt=1.
- Tick during busy → overrun=1 and positions advance once only. pause=1 or ena=0 → tick ignored, positions unchanged.
- rst_n low at the cycle after the first write → all positions return to reset values, busy=0, no done pulse.
